// File: rtl/dcs_read_initiator.sv
// rtl/dcs_read_initiator.sv - DCS read sequencer: set max return size, read, bus turnaround, collect response
module dcs_read_initiator #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF,
    parameter logic [1:0]  VC      = 2'd0
) (
    input  logic        clk_periph,
    input  logic        rstn,
    input  logic        rd_req,
    input  logic [7:0]  rd_addr,
    input  logic [7:0]  rd_len,
    output logic [23:0] host_tx_cmd,
    output logic        host_tx_cmd_req,
    input  logic        host_tx_cmd_ack,
    output logic        host_bta_req,
    input  logic        host_dphy_direction,
    input  logic [23:0] host_rx_cmd,
    input  logic        host_rx_cmd_valid,
    input  logic [31:0] host_rx_payload,
    input  logic        host_rx_payload_valid,
    input  logic        host_rx_payload_last,
    output logic        rd_busy,
    output logic [31:0] rd_data,
    output logic        rd_data_valid,
    output logic        rd_done,
    output logic [1:0]  rd_status,
    output logic [15:0] rd_err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_MRS, S_SEND_RD, S_BTA, S_WAIT_DIR, S_WAIT_RESP, S_RX_LONG, S_DONE
    } state_t;

    localparam logic [5:0] DT_MRS    = 6'h37;
    localparam logic [5:0] DT_READ   = 6'h06;
    localparam logic [5:0] DT_ACK_ER = 6'h02;
    localparam logic [5:0] DT_SHORT1 = 6'h21;
    localparam logic [5:0] DT_SHORT2 = 6'h22;
    localparam logic [5:0] DT_LONG_A = 6'h1C;
    localparam logic [5:0] DT_LONG_B = 6'h1A;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  mrs_q, mrs_d;
    logic [15:0] cnt_q, cnt_d;
    logic        dir_q;
    logic [23:0] tx_cmd_q, tx_cmd_d;
    logic        tx_req_q, tx_req_d;
    logic        bta_q, bta_d;
    logic        busy_q, busy_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] err_q, err_d;

    logic [7:0]  len_eff;
    logic [5:0]  rx_dt;
    logic [15:0] rx_wc;
    logic [15:0] cnt_inc;
    logic        timed_out;
    logic        counting;

    assign len_eff   = (rd_len == 8'd0) ? 8'd1 : rd_len;
    assign rx_dt     = host_rx_cmd[5:0];
    assign rx_wc     = host_rx_cmd[23:8];
    assign cnt_inc   = cnt_q + 16'd1;
    assign timed_out = (cnt_inc == TIMEOUT);

    // Next-state and registered-output computation for the whole read sequence
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        mrs_d    = mrs_q;
        tx_cmd_d = tx_cmd_q;
        tx_req_d = tx_req_q;
        bta_d    = 1'b0;
        busy_d   = busy_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        status_d = status_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    addr_d   = rd_addr;
                    len_d    = len_eff;
                    busy_d   = 1'b1;
                    tx_req_d = 1'b1;
                    if (len_eff != mrs_q) begin
                        tx_cmd_d = {8'h00, len_eff, VC, DT_MRS};
                        state_d  = S_SEND_MRS;
                    end else begin
                        tx_cmd_d = {8'h00, rd_addr, VC, DT_READ};
                        state_d  = S_SEND_RD;
                    end
                end
            end
            S_SEND_MRS: begin
                if (tx_req_q && host_tx_cmd_ack) begin
                    tx_req_d = 1'b0;
                    mrs_d    = len_q;
                    tx_cmd_d = {8'h00, addr_q, VC, DT_READ};
                    state_d  = S_SEND_RD;
                end else if (timed_out) begin
                    tx_req_d = 1'b0;
                    status_d = 2'b10;
                    state_d  = S_DONE;
                end
            end
            S_SEND_RD: begin
                if (tx_req_q && host_tx_cmd_ack) begin
                    tx_req_d = 1'b0;
                    bta_d    = 1'b1;
                    state_d  = S_BTA;
                end else if (timed_out) begin
                    tx_req_d = 1'b0;
                    status_d = 2'b10;
                    state_d  = S_DONE;
                end else if (!tx_req_q) begin
                    // Arriving from SEND_MRS: request drops for one cycle between packets
                    tx_req_d = 1'b1;
                end
            end
            S_BTA: begin
                state_d = S_WAIT_DIR;
            end
            S_WAIT_DIR: begin
                if (host_dphy_direction && !dir_q) begin
                    state_d = S_WAIT_RESP;
                end else if (timed_out) begin
                    status_d = 2'b10;
                    state_d  = S_DONE;
                end
            end
            S_WAIT_RESP: begin
                if (host_rx_cmd_valid) begin
                    status_d = 2'b00;
                    state_d  = S_DONE;
                    case (rx_dt)
                        DT_SHORT1: begin
                            data_d  = {24'h0, host_rx_cmd[15:8]};
                            valid_d = 1'b1;
                        end
                        DT_SHORT2: begin
                            data_d  = {16'h0, host_rx_cmd[23:8]};
                            valid_d = 1'b1;
                        end
                        DT_ACK_ER: begin
                            err_d    = rx_wc;
                            status_d = 2'b01;
                        end
                        DT_LONG_A, DT_LONG_B: begin
                            if (rx_wc != 16'd0) begin
                                state_d = S_RX_LONG;
                            end
                        end
                        default: status_d = 2'b11;
                    endcase
                end else if (timed_out) begin
                    status_d = 2'b10;
                    state_d  = S_DONE;
                end
            end
            S_RX_LONG: begin
                if (host_rx_payload_valid) begin
                    data_d  = host_rx_payload;
                    valid_d = 1'b1;
                    if (host_rx_payload_last) begin
                        status_d = 2'b00;
                        state_d  = S_DONE;
                    end
                end else if (timed_out) begin
                    status_d = 2'b10;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    // Wait-state cycle counter restarts whenever the state changes
    always_comb begin
        counting = (state_q == S_SEND_MRS) || (state_q == S_SEND_RD) || (state_q == S_WAIT_DIR) ||
                   (state_q == S_WAIT_RESP) || (state_q == S_RX_LONG);
        if (!counting || (state_d != state_q)) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    // State, captured request, counter and registered outputs
    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            addr_q   <= 8'd0;
            len_q    <= 8'd0;
            mrs_q    <= 8'd1;
            cnt_q    <= 16'd0;
            dir_q    <= 1'b0;
            tx_cmd_q <= 24'd0;
            tx_req_q <= 1'b0;
            bta_q    <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= 32'd0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            status_q <= 2'b00;
            err_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            mrs_q    <= mrs_d;
            cnt_q    <= cnt_d;
            dir_q    <= host_dphy_direction;
            tx_cmd_q <= tx_cmd_d;
            tx_req_q <= tx_req_d;
            bta_q    <= bta_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    assign host_tx_cmd     = tx_cmd_q;
    assign host_tx_cmd_req = tx_req_q;
    assign host_bta_req    = bta_q;
    assign rd_busy         = busy_q;
    assign rd_data         = data_q;
    assign rd_data_valid   = valid_q;
    assign rd_done         = done_q;
    assign rd_status       = status_q;
    assign rd_err_code     = err_q;

endmodule

// File: tb/tb_dcs_read_initiator.sv
// tb/tb_dcs_read_initiator.sv - directed vector bench for dcs_read_initiator
module tb_dcs_read_initiator;

    logic        clk_periph = 1'b0;
    logic        rstn = 1'b0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_addr = 8'd0;
    logic [7:0]  rd_len = 8'd0;
    logic [23:0] host_tx_cmd;
    logic        host_tx_cmd_req;
    logic        host_tx_cmd_ack = 1'b0;
    logic        host_bta_req;
    logic        host_dphy_direction = 1'b0;
    logic [23:0] host_rx_cmd = 24'd0;
    logic        host_rx_cmd_valid = 1'b0;
    logic [31:0] host_rx_payload = 32'd0;
    logic        host_rx_payload_valid = 1'b0;
    logic        host_rx_payload_last = 1'b0;
    logic        rd_busy;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        rd_done;
    logic [1:0]  rd_status;
    logic [15:0] rd_err_code;

    dcs_read_initiator #(.TIMEOUT(16'd16), .VC(2'd0)) dut (
        .clk_periph(clk_periph), .rstn(rstn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .host_tx_cmd(host_tx_cmd), .host_tx_cmd_req(host_tx_cmd_req), .host_tx_cmd_ack(host_tx_cmd_ack),
        .host_bta_req(host_bta_req), .host_dphy_direction(host_dphy_direction),
        .host_rx_cmd(host_rx_cmd), .host_rx_cmd_valid(host_rx_cmd_valid),
        .host_rx_payload(host_rx_payload), .host_rx_payload_valid(host_rx_payload_valid),
        .host_rx_payload_last(host_rx_payload_last),
        .rd_busy(rd_busy), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .rd_done(rd_done), .rd_status(rd_status), .rd_err_code(rd_err_code)
    );

    always #5 clk_periph = ~clk_periph;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  len;
        logic [5:0]  dt;
        logic [15:0] hdata;
        logic [31:0] payload;
        logic        exp_mrs;
        logic [7:0]  exp_len_eff;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_status;
        logic [15:0] exp_err;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int done_total = 0;
    logic [23:0] tx_log[$];
    int   ack_wait = 0;
    logic [23:0] held_cmd = 24'd0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Transmit side: acknowledge each packet three cycles after its request rises
    always @(negedge clk_periph) begin
        if (host_tx_cmd_ack) begin
            host_tx_cmd_ack = 1'b0;
            ack_wait = 0;
        end else if (host_tx_cmd_req) begin
            if (ack_wait == 0) begin
                held_cmd = host_tx_cmd;
            end else begin
                check("tx_cmd_stable", ack_wait, {8'h0, host_tx_cmd}, {8'h0, held_cmd});
            end
            ack_wait++;
            if (ack_wait >= 3) begin
                host_tx_cmd_ack = 1'b1;
                tx_log.push_back(host_tx_cmd);
            end
        end else begin
            ack_wait = 0;
        end
    end

    // Completion pulse counter
    always @(negedge clk_periph) begin
        if (rd_done) done_total++;
    end

    task automatic start_req(input int idx, input logic [7:0] a, input logic [7:0] l);
        @(negedge clk_periph);
        rd_addr = a;
        rd_len  = l;
        rd_req  = 1'b1;
        @(negedge clk_periph);
        rd_req = 1'b0;
        check("req_latency", idx, {31'h0, host_tx_cmd_req}, 32'd1);
        check("busy_on_accept", idx, {31'h0, rd_busy}, 32'd1);
    endtask

    task automatic wait_bta(input int idx, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_periph);
            if (host_bta_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL bta_wait[%0d]: got no bus turnaround expected one within 60 cycles", idx);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        logic        seen;
        logic        got_done;
        int          nvalid;
        logic [31:0] word;
        logic [1:0]  st;
        tx_log.delete();
        start_req(idx, v.addr, v.len);
        wait_bta(idx, seen);
        if (seen) begin
            @(negedge clk_periph);
            host_dphy_direction = 1'b1;
            @(negedge clk_periph);
            host_rx_cmd       = {v.hdata, 2'b00, v.dt};
            host_rx_cmd_valid = 1'b1;
            @(negedge clk_periph);
            host_rx_cmd_valid = 1'b0;
            if ((v.dt == 6'h1C || v.dt == 6'h1A) && v.hdata != 16'd0) begin
                host_rx_payload       = v.payload;
                host_rx_payload_valid = 1'b1;
                host_rx_payload_last  = 1'b1;
                @(negedge clk_periph);
                host_rx_payload_valid = 1'b0;
                host_rx_payload_last  = 1'b0;
            end
            got_done = 1'b0;
            nvalid = 0;
            word = 32'd0;
            st = 2'b00;
            for (int c = 0; c < 20; c++) begin
                if (rd_data_valid) begin
                    nvalid++;
                    word = rd_data;
                end
                if (rd_done) begin
                    got_done = 1'b1;
                    st = rd_status;
                    break;
                end
                @(negedge clk_periph);
            end
            check("done_seen", idx, {31'h0, got_done}, 32'd1);
            check("status", idx, {30'h0, st}, {30'h0, v.exp_status});
            check("data_count", idx, nvalid, {31'h0, v.exp_valid});
            if (v.exp_valid) check("data", idx, word, v.exp_data);
            if (v.exp_status == 2'b01) check("err_code", idx, {16'h0, rd_err_code}, {16'h0, v.exp_err});
            @(negedge clk_periph);
            check("busy_after_done", idx, {31'h0, rd_busy}, 32'd0);
        end
        host_dphy_direction = 1'b0;
        check("tx_count", idx, tx_log.size(), v.exp_mrs ? 32'd2 : 32'd1);
        if (tx_log.size() >= 1) begin
            check("tx_first", idx, {8'h0, tx_log[0]},
                  v.exp_mrs ? {8'h0, 8'h00, v.exp_len_eff, 2'b00, 6'h37} : {8'h0, 8'h00, v.addr, 2'b00, 6'h06});
            check("tx_last", idx, {8'h0, tx_log[tx_log.size()-1]}, {8'h0, 8'h00, v.addr, 2'b00, 6'h06});
        end
        @(negedge clk_periph);
    endtask

    vec_t vecs[8];
    vec_t post;

    initial begin
        logic seen;
        int   n;
        int   d0;
        logic got_done;

        vecs[0] = '{8'h0A, 8'd1, 6'h21, 16'h009C, 32'h0,        1'b0, 8'd1, 1'b1, 32'h0000009C, 2'b00, 16'h0};
        vecs[1] = '{8'h04, 8'd4, 6'h1C, 16'h0004, 32'h270E0761, 1'b1, 8'd4, 1'b1, 32'h270E0761, 2'b00, 16'h0};
        vecs[2] = '{8'h04, 8'd4, 6'h1C, 16'h0004, 32'h270E0761, 1'b0, 8'd4, 1'b1, 32'h270E0761, 2'b00, 16'h0};
        vecs[3] = '{8'h05, 8'd4, 6'h02, 16'h0100, 32'h0,        1'b0, 8'd4, 1'b0, 32'h0,        2'b01, 16'h0100};
        vecs[4] = '{8'h33, 8'd2, 6'h22, 16'hABCD, 32'h0,        1'b1, 8'd2, 1'b1, 32'h0000ABCD, 2'b00, 16'h0};
        vecs[5] = '{8'h10, 8'd0, 6'h21, 16'h1255, 32'h0,        1'b1, 8'd1, 1'b1, 32'h00000055, 2'b00, 16'h0};
        vecs[6] = '{8'h11, 8'd1, 6'h1A, 16'h0000, 32'h0,        1'b0, 8'd1, 1'b0, 32'h0,        2'b00, 16'h0};
        vecs[7] = '{8'h12, 8'd1, 6'h3F, 16'h0000, 32'h0,        1'b0, 8'd1, 1'b0, 32'h0,        2'b11, 16'h0};
        post    = '{8'h0A, 8'd1, 6'h21, 16'h009C, 32'h0,        1'b0, 8'd1, 1'b1, 32'h0000009C, 2'b00, 16'h0};

        repeat (3) @(negedge clk_periph);
        check("rst_busy", 0, {31'h0, rd_busy}, 32'd0);
        check("rst_tx_req", 0, {31'h0, host_tx_cmd_req}, 32'd0);
        check("rst_tx_cmd", 0, {8'h0, host_tx_cmd}, 32'd0);
        check("rst_bta", 0, {31'h0, host_bta_req}, 32'd0);
        check("rst_done", 0, {31'h0, rd_done}, 32'd0);
        check("rst_status", 0, {30'h0, rd_status}, 32'd0);
        check("rst_data", 0, rd_data, 32'd0);
        check("rst_valid", 0, {31'h0, rd_data_valid}, 32'd0);
        check("rst_err", 0, {16'h0, rd_err_code}, 32'd0);
        rstn = 1'b1;
        @(negedge clk_periph);

        for (int i = 0; i < 8; i++) begin
            run_txn(i, vecs[i]);
        end

        // Direction never rises: timeout 16 cycles into WAIT_DIR, with a stray
        // request and stray rx strobes in between that must be ignored
        tx_log.delete();
        d0 = done_total;
        start_req(100, 8'h20, 8'd1);
        wait_bta(100, seen);
        n = 0;
        got_done = 1'b0;
        while (seen && n < 40) begin
            @(negedge clk_periph);
            n++;
            rd_addr = 8'h77;
            rd_len  = 8'd9;
            rd_req  = (n == 3);
            host_rx_cmd           = {16'h0042, 2'b00, 6'h21};
            host_rx_cmd_valid     = (n == 5);
            host_rx_payload       = 32'hDEADBEEF;
            host_rx_payload_valid = (n == 7);
            host_rx_payload_last  = (n == 7);
            if (rd_done) begin
                got_done = 1'b1;
                check("timeout_status", 100, {30'h0, rd_status}, 32'd2);
                break;
            end
        end
        rd_req = 1'b0;
        host_rx_cmd_valid = 1'b0;
        host_rx_payload_valid = 1'b0;
        host_rx_payload_last = 1'b0;
        check("timeout_done_seen", 100, {31'h0, got_done}, 32'd1);
        check("timeout_cycles", 100, n, 32'd17);
        repeat (4) @(negedge clk_periph);
        check("timeout_busy", 100, {31'h0, rd_busy}, 32'd0);
        check("busy_req_ignored_tx", 100, tx_log.size(), 32'd1);
        check("busy_req_ignored_done", 100, done_total - d0, 32'd1);

        // Reset in the middle of a long-packet receive
        tx_log.delete();
        start_req(200, 8'h40, 8'd3);
        wait_bta(200, seen);
        if (seen) begin
            @(negedge clk_periph);
            host_dphy_direction = 1'b1;
            @(negedge clk_periph);
            host_rx_cmd       = {16'h0008, 2'b00, 6'h1C};
            host_rx_cmd_valid = 1'b1;
            @(negedge clk_periph);
            host_rx_cmd_valid     = 1'b0;
            host_rx_payload       = 32'h11223344;
            host_rx_payload_valid = 1'b1;
            @(negedge clk_periph);
            host_rx_payload_valid = 1'b0;
            check("rxlong_word_valid", 200, {31'h0, rd_data_valid}, 32'd1);
            check("rxlong_word", 200, rd_data, 32'h11223344);
            @(negedge clk_periph);
        end
        check("rxlong_mrs_sent", 200, tx_log.size(), 32'd2);
        d0 = done_total;
        rstn = 1'b0;
        host_dphy_direction = 1'b0;
        @(negedge clk_periph);
        check("mid_rst_busy", 200, {31'h0, rd_busy}, 32'd0);
        check("mid_rst_data", 200, rd_data, 32'd0);
        check("mid_rst_valid", 200, {31'h0, rd_data_valid}, 32'd0);
        check("mid_rst_err", 200, {16'h0, rd_err_code}, 32'd0);
        check("mid_rst_tx_cmd", 200, {8'h0, host_tx_cmd}, 32'd0);
        check("mid_rst_status", 200, {30'h0, rd_status}, 32'd0);
        @(negedge clk_periph);
        rstn = 1'b1;
        repeat (4) @(negedge clk_periph);
        check("mid_rst_no_done", 200, done_total - d0, 32'd0);

        run_txn(300, post);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcs_read_initiator.md
DCS_READ_INITIATOR -- requirements
Module: dcs_read_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'hFFFF: cycles allowed per wait state.
REQ-002 SHALL have parameter VC, default 2'd0: virtual channel placed in every transmitted header.
REQ-003 SHALL have clk_periph  in  1  clock; all logic on rising edge.
REQ-004 SHALL have rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have rd_req  in  1  one-cycle read request pulse.
REQ-006 SHALL have rd_addr  in  8  DCS register to read.
REQ-007 SHALL have rd_len  in  8  requested return byte count (0 treated as 1).
REQ-008 SHALL have host_tx_cmd  out  24  short-packet header {data1, data0, VC, DT[5:0]}.
REQ-009 SHALL have host_tx_cmd_req / host_tx_cmd_ack  out/in  1/1  transmit handshake.
REQ-010 SHALL have host_bta_req  out  1  one-cycle bus-turnaround request.
REQ-011 SHALL have host_dphy_direction  in  1  1 = lane reversed (peripheral driving).
REQ-012 SHALL have host_rx_cmd / host_rx_cmd_valid  in  24/1  received header {data1, data0, VC, DT}.
REQ-013 SHALL have host_rx_payload / host_rx_payload_valid / host_rx_payload_last  in  32/1/1  long-packet words, byte0 in [7:0].
REQ-014 SHALL have rd_busy  out  1  high from request accept to rd_done.
REQ-015 SHALL have rd_data / rd_data_valid  out  32/1  returned data words.
REQ-016 SHALL have rd_done / rd_status  out  1/2  completion pulse; 00 ok, 01 acknowledge-error, 10 timeout, 11 unexpected DT.
REQ-017 SHALL have rd_err_code  out  16  error report from DT 0x02 response.

Function
REQ-018 SHALL implement FSM states IDLE, SEND_MRS, SEND_RD, BTA, WAIT_DIR, WAIT_RESP, RX_LONG, DONE.
REQ-019 IDLE: rd_req accepted only here; rd_req in any other state ignored, no queuing.
REQ-020 On accept: capture rd_addr/rd_len; go SEND_MRS if effective length != mrs_reg, else SEND_RD.
REQ-021 mrs_reg: 8 bits, reset 8'd1; updated to effective length on ack of the 0x37 packet.
REQ-022 SEND_MRS: host_tx_cmd = {8'h00, len, VC, 6'h37}; req high until ack sampled, cleared same edge; then SEND_RD.
REQ-023 SEND_RD: host_tx_cmd = {8'h00, addr, VC, 6'h06}; same handshake; then BTA.
REQ-024 host_tx_cmd SHALL remain stable while host_tx_cmd_req is high.
REQ-025 BTA: host_bta_req high exactly one cycle, then WAIT_DIR.
REQ-026 WAIT_DIR: wait for host_dphy_direction rising edge (registered compare), then WAIT_RESP.
REQ-027 WAIT_RESP on host_rx_cmd_valid, by DT:
- 0x21: rd_data = {24'h0, data0}, valid one cycle.
- 0x22: rd_data = {16'h0, data1, data0}.
- 0x02: rd_err_code = {data1, data0}; status 01.
- 0x1C or 0x1A: go RX_LONG.
- Other DT: status 11.
- Non-long cases go DONE.
REQ-028 RX_LONG: each host_rx_payload_valid word forwarded to rd_data with rd_data_valid one cycle later; word carrying last goes DONE, status 00.
REQ-029 Long word count {data1, data0} of 0 SHALL go directly to DONE without waiting for payload.
REQ-030 Timeout counter: 16 bits, cleared on entry to SEND_MRS, SEND_RD, WAIT_DIR, WAIT_RESP, RX_LONG.
REQ-031 Counter increments each cycle in those states; reaching TIMEOUT goes DONE with status 10.
REQ-032 On timeout in SEND_MRS/SEND_RD, host_tx_cmd_req SHALL drop the same cycle.
REQ-033 rx header/payload strobes outside WAIT_RESP/RX_LONG SHALL be ignored.
REQ-034 DONE: rd_done high one cycle, rd_status valid that cycle, rd_busy falls next cycle, return IDLE.
REQ-035 Latency: rd_req to host_tx_cmd_req = 1 cycle.

Reset
REQ-036 On rstn low, at any time: state IDLE; all outputs 0 except rd_status 00; mrs_reg 8'd1; counter 0.
REQ-037 A transfer in progress SHALL be abandoned with no rd_done.

Verification
REQ-038 rd_req addr 0x0A, len 1, ack after 3 cycles, direction rise, rx 0x21 data0 0x9C -> no 0x37 packet; one 0x06 packet with data0 0x0A; rd_data 0x0000009C; status 00.
REQ-039 len 4, addr 0x04, rx 0x1C wc 4, one payload word 0x27_0E_07_61 with last -> 0x37 packet data0 04 precedes 0x06; rd_data 0x270E0761; mrs_reg 4; status 00.
REQ-040 Repeat with len 4 -> no 0x37 packet sent.
REQ-041 rx DT 0x02 with data 0x0100 -> rd_err_code 0x0100, status 01.
REQ-042 TIMEOUT=16, direction never rises -> rd_done 16 cycles after WAIT_DIR entry, status 10.
REQ-043 Checks:
- rd_req while busy -> no effect.
- rstn low during RX_LONG -> outputs 0, no rd_done; next request completes normally.
